// File: rtl/cache_lookup_ctrl_pkg.sv
// Shared definitions for the cache lookup/refill controller.
// Holds the width constants, the address field positions, the FSM state
// encoding and a word-select helper.
package cache_pkg;

  localparam int WAYS       = 8;
  localparam int MAIN_TAG_W = 20;
  localparam int HALT_W     = 4;
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;

  // Address field positions.
  localparam int MAIN_MSB = 31;
  localparam int MAIN_LSB = 12;
  localparam int HALT_MSB = 11;
  localparam int HALT_LSB = 8;
  localparam int WORD_MSB = 4;
  localparam int WORD_LSB = 2;
  localparam int LINE_LSB = 5;

  // state    | meaning
  // ST_IDLE  | ready for a CPU read
  // ST_PROBE | checking one halt-tag candidate way per cycle
  // ST_MISS  | waiting for the memory line (mem_req held)
  // ST_FILL  | one-cycle write of the refilled line into the victim way
  // ST_RESP  | one-cycle response strobe to the CPU
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_MISS  = 3'd2,
    ST_FILL  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Picks 32-bit word idx out of a line.
  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [2:0]        idx);
    return line[{idx, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_lookup_ctrl_if.sv
// Bundle of the CPU, cache-set and memory signals of the lookup controller.
// master: controller side; slave: CPU/set/memory environment side.
interface cache_lookup_ctrl_if;

  logic                           cpu_req;
  logic [31:0]                    cpu_addr;
  logic                           cpu_ready;
  logic                           cpu_rvalid;
  logic [31:0]                    cpu_rdata;
  logic                           cpu_hit;

  logic [cache_pkg::WAYS*cache_pkg::HALT_W-1:0] halt_tag_i;
  logic                           way_valid_i;
  logic [cache_pkg::MAIN_TAG_W-1:0] main_tag_i;
  logic [cache_pkg::LINE_W-1:0]   line_i;
  logic [cache_pkg::WAYS-1:0]     way_sel;
  logic                           set_wr;
  logic                           set_viv;
  logic [23:0]                    set_tag;
  logic [cache_pkg::LINE_W-1:0]   set_data;

  logic                           mem_req;
  logic [31:0]                    mem_addr;
  logic                           mem_ack;
  logic [cache_pkg::LINE_W-1:0]   mem_data;

  modport master (
    input  cpu_req, cpu_addr, halt_tag_i, way_valid_i, main_tag_i, line_i,
           mem_ack, mem_data,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit, way_sel, set_wr,
           set_viv, set_tag, set_data, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, halt_tag_i, way_valid_i, main_tag_i, line_i,
           mem_ack, mem_data,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit, way_sel, set_wr,
           set_viv, set_tag, set_data, mem_req, mem_addr
  );

endinterface

// File: rtl/cache_lookup_ctrl_ffs.sv
// find_first_set: one-hot of the lowest set bit of vec_i, plus an any-set flag.
//   vec_i    in  WAYS  input vector
//   onehot_o out WAYS  lowest set bit only (0 when vec_i == 0)
//   any_o    out 1     vec_i != 0
module find_first_set
  import cache_pkg::*;
(
  input  logic [WAYS-1:0] vec_i,
  output logic [WAYS-1:0] onehot_o,
  output logic            any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + WAYS'(1));
  assign any_o    = |vec_i;

endmodule

// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: lookup and refill controller for an 8-way cache set.
// Filters ways by halt tag, probes survivors one per cycle, refills on miss.
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-low reset
//   bus    cache_lookup_ctrl_if.master  CPU, set and memory signals
module cache_lookup_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  cache_lookup_ctrl_if.master  bus
);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [WAYS-1:0]     cand_q, cand_d;
  logic [WAYS-1:0]     vld_q, vld_d;
  logic [2:0]          rr_q, rr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                hit_q, hit_d;

  logic [WAYS-1:0]     halt_match;
  logic [WAYS-1:0]     probe_oh;
  logic                probe_any;
  logic [WAYS-1:0]     inv_oh;
  logic                inv_any;
  logic [WAYS-1:0]     victim_oh;
  logic                probe_hit;

  find_first_set u_ffs_probe (
    .vec_i    (cand_q),
    .onehot_o (probe_oh),
    .any_o    (probe_any)
  );

  find_first_set u_ffs_victim (
    .vec_i    (~vld_q),
    .onehot_o (inv_oh),
    .any_o    (inv_any)
  );

  // Only ways the controller itself has filled can be candidates.
  always_comb begin
    halt_match = '0;
    for (int k = 0; k < WAYS; k++) begin
      halt_match[k] = vld_q[k] &&
        (bus.halt_tag_i[k*HALT_W +: HALT_W] == bus.cpu_addr[HALT_MSB:HALT_LSB]);
    end
  end

  assign victim_oh = inv_any ? inv_oh : (WAYS'(1) << rr_q);
  assign probe_hit = probe_any && bus.way_valid_i &&
                     (bus.main_tag_i == addr_q[MAIN_MSB:MAIN_LSB]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cand_d  = cand_q;
    vld_d   = vld_q;
    rr_d    = rr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          cand_d  = halt_match;
          state_d = (|halt_match) ? ST_PROBE : ST_MISS;
        end
      end
      ST_PROBE: begin
        if (probe_hit) begin
          rdata_d = word_of(bus.line_i, addr_q[WORD_MSB:WORD_LSB]);
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cand_d = cand_q & ~probe_oh;
          if ((cand_q & ~probe_oh) == '0) state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        if (bus.mem_ack) begin
          line_d  = bus.mem_data;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        vld_d = vld_q | victim_oh;
        // Round-robin only advances when it actually chose the victim.
        if (!inv_any) rr_d = rr_q + 3'd1;
        rdata_d = word_of(line_q, addr_q[WORD_MSB:WORD_LSB]);
        hit_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cand_q  <= '0;
      vld_q   <= '0;
      rr_q    <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cand_q  <= cand_d;
      vld_q   <= vld_d;
      rr_q    <= rr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.cpu_ready  = (state_q == ST_IDLE);
  assign bus.cpu_rvalid = (state_q == ST_RESP);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_hit    = hit_q;

  assign bus.way_sel  = (state_q == ST_PROBE) ? probe_oh :
                        (state_q == ST_FILL)  ? victim_oh : '0;
  assign bus.set_wr   = (state_q == ST_FILL);
  assign bus.set_viv  = (state_q == ST_FILL);
  assign bus.set_tag  = (state_q == ST_FILL) ? addr_q[MAIN_MSB:HALT_LSB] : '0;
  assign bus.set_data = (state_q == ST_FILL) ? line_q : '0;

  assign bus.mem_req  = (state_q == ST_MISS);
  assign bus.mem_addr = (state_q == ST_MISS) ? {addr_q[31:LINE_LSB], 5'b0} : '0;

endmodule

// File: doc/cache_lookup_ctrl.md
Name: cache_lookup_ctrl

Overview:
Lookup and refill controller that drives the 8-way cache set's write and way-select interface. It takes a CPU read, uses the 4-bit halt tags to filter candidate ways, and probes the surviving ways one per cycle through the set's one-hot way select, comparing main tag and valid bit. On a miss it fetches the 256-bit line from memory over a req/ack handshake, picks a victim, and writes tag, data and valid bit into the set before returning the word.

Parameters:
WAYS, 8, number of ways; way_sel is one-hot WAYS bits
MAIN_TAG_W, 20, main tag width, taken from addr[31:12]
HALT_W, 4, halt tag width, taken from addr[11:8]
LINE_W, 256, line width in bits (8 x 32-bit words, addr[4:2] selects the word)

Ports:
clk  in  1  clock, all state changes on the rising edge
reset  in  1  reset, asynchronous, active-low
cpu_req  in  1  read request, must be held until accepted
cpu_addr  in  32  byte address of the read
cpu_ready  out  1  high only in IDLE; a request is accepted when cpu_req && cpu_ready
cpu_rvalid  out  1  one-cycle response strobe
cpu_rdata  out  32  read word, valid while cpu_rvalid is high
cpu_hit  out  1  1 = hit, 0 = refilled; valid while cpu_rvalid is high
halt_tag_i  in  32  halt tags from the set, packed; way k occupies [4k+3:4k]
way_valid_i  in  1  valid bit of the currently selected way (set out_viv)
main_tag_i  in  20  main tag of the currently selected way
line_i  in  256  data of the currently selected way
way_sel  out  8  one-hot way select (set decOut1b); 0 when not probing or filling
set_wr  out  1  write enable to the set (regWrite)
set_viv  out  1  valid bit to write; 1 during FILL
set_tag  out  24  tag to write: {addr[31:12], addr[11:8]}
set_data  out  256  line to write
mem_req  out  1  memory line-read request
mem_addr  out  32  line address {addr[31:5], 5'b0}
mem_ack  in  1  memory acknowledge; mem_data is valid in the same cycle
mem_data  in  256  refill line

Behaviour:
- Reset state:
  - FSM in IDLE; addr_q = 0; cand = 0; shadow valid vector vld = 0; round-robin pointer rr = 0.
  - Outputs: cpu_ready = 1; cpu_rvalid = 0; cpu_rdata = 0; cpu_hit = 0; way_sel = 0; set_wr = 0; set_viv = 0; set_tag = 0; set_data = 0; mem_req = 0; mem_addr = 0.
- States are IDLE, PROBE, MISS, FILL and RESP.
- IDLE (on accept):
  - Latch addr_q.
  - cand = {k : halt_tag_i[k] == addr[11:8] and vld[k] == 1}.
  - If cand == 0, go to MISS; otherwise go to PROBE.
- PROBE:
  - way_sel = one-hot of the lowest set bit of cand.
  - Hit if way_valid_i && main_tag_i == addr_q[31:12]. On a hit, register cpu_rdata = line_i[addr_q[4:2]*32 +: 32] and cpu_hit = 1, then go to RESP.
  - On a mismatch, clear that bit of cand. If the result is 0, go to MISS; otherwise stay in PROBE.
- MISS:
  - mem_req = 1 and mem_addr is held stable until mem_ack is sampled high at a rising edge.
  - On that edge, latch mem_data into the line buffer and go to FILL.
  - mem_ack outside MISS is ignored.
- FILL (exactly one cycle):
  - set_wr = 1, set_viv = 1, way_sel = victim, set_tag and set_data driven from addr_q and the line buffer.
  - Victim = lowest-index way with vld = 0. If every way is valid, victim = rr and rr increments mod 8 (7 wraps to 0). rr is unchanged when an invalid way is used.
  - vld[victim] <= 1. cpu_rdata = word addr_q[4:2] of the buffer, cpu_hit = 0. Go to RESP.
- RESP: cpu_rvalid = 1 for exactly one cycle, then go to IDLE.
- Latency, counting cycles after the accept edge:
  - Hit on the n-th probed candidate (n = 1..8): cpu_rvalid is high in cycle n+1.
  - Miss: cpu_rvalid is high 2 cycles after the mem_ack edge.
- cpu_req while cpu_ready = 0 has no effect; the requester holds its request.
- Reset asserted mid-operation: all state and outputs clear immediately. mem_req drops without waiting for ack; any in-flight ack is discarded.

Decomposition:
- Shared package cache_pkg holds:
  - width constants (MAIN_TAG_W, HALT_W, LINE_W, WAYS);
  - address field positions (main [31:12], halt [11:8], word [4:2]);
  - the FSM state enum.
- Sub-module find_first_set: 8-bit input to one-hot lowest set bit, plus an any-set flag. Two instances, one for the probe candidate and one for the invalid-way victim.

Test Plan:
1. After reset, read 0x0000_1234. Expect a direct MISS with mem_addr = 0x0000_1220. Ack with words 0..7 = 0xA0..0xA7. Expect a FILL with way_sel = 0x01 and set_tag = 0x000012. Expect cpu_rdata = 0xA5 and cpu_hit = 0.
2. Read 0x0000_1234 again, with halt_tag_i[3:0] = 2, main_tag_i = 0x00001 and way_valid_i = 1. Expect way_sel = 0x01 in cycle 1 and cpu_rvalid in cycle 2 with cpu_hit = 1. Expect no mem_req.
3. Fill 0x0000_1200 (way 0) then 0x0000_2200 (way 1); both have halt tag 2. Read 0x0000_2200. Expect way 0 probed then way 1, a hit, and cpu_rvalid in cycle 3.
4. Fill 9 lines with distinct addresses. The 9th fill has victim way 0 (way_sel = 0x01) and rr becomes 1. A 10th distinct fill uses way_sel = 0x02.
5. Hold mem_ack low for 20 cycles in MISS. Expect mem_req = 1 and mem_addr stable throughout, and cpu_ready = 0.
6. Assert reset while mem_req = 1. Expect mem_req = 0 and cpu_ready = 1 immediately. A repeat read of a previously filled address misses.
